// File: rtl/mem_pkg.sv
// mem_pkg: shared types and field indices for the MEM stage slice.
// Branch condition codes, M-bundle bit positions, flag positions, FSM states.
package mem_pkg;

    typedef enum logic [2:0] {
        NE = 3'b000,
        EQ = 3'b001,
        GT = 3'b010,
        LT = 3'b011,
        GE = 3'b100,
        LE = 3'b101,
        OV = 3'b110,
        UN = 3'b111
    } bcond_t;

    localparam int M_RD = 0;
    localparam int M_WR = 1;
    localparam int M_BR = 2;

    localparam int F_ZR  = 2;
    localparam int F_NEG = 1;
    localparam int F_OV  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_slice_if.sv
// mem_slice_if: req/ack data-memory port between the MEM stage and memory.
// master = MEM stage, slave = memory.
interface mem_slice_if #(
    parameter int DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/branch_unit.sv
// branch_unit: evaluates a branch condition code against {zr,neg,ov}.
// Purely combinational.
module branch_unit
    import mem_pkg::*;
(
    input  logic [2:0] bcond_i,
    input  logic [2:0] flags_i,
    output logic       cond_true_o
);

    logic zr;
    logic neg;
    logic ov;

    assign zr  = flags_i[F_ZR];
    assign neg = flags_i[F_NEG];
    assign ov  = flags_i[F_OV];

    // Decode condition code to a taken/not-taken decision
    always_comb begin
        cond_true_o = 1'b0;
        unique case (bcond_t'(bcond_i))
            NE: cond_true_o = ~zr;
            EQ: cond_true_o = zr;
            GT: cond_true_o = ~zr & ~neg;
            LT: cond_true_o = neg;
            GE: cond_true_o = zr | ~neg;
            LE: cond_true_o = zr | neg;
            OV: cond_true_o = ov;
            UN: cond_true_o = 1'b1;
            default: cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_slice.sv
// mem_slice: MEM pipeline stage - stage register, flag register, branch
// resolution, req/ack memory FSM and MEM/WB register. Option: MEM_TIMEOUT_EN.
module mem_slice
    import mem_pkg::*;
#(
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    WB_in,
    input  logic [2:0]    M_in,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] result,
    input  logic [2:0]    flags_in,
    input  logic [2:0]    flags_we,
    input  logic [DW-1:0] PCbranch,
    input  logic [2:0]    bcond,
    input  logic          ex_valid,
    mem_slice_if.master   mem,
    output logic          stall,
    output logic          taken,
    output logic [DW-1:0] PCtarget,
    output logic [2:0]    flags,
    output logic [1:0]    WB,
    output logic [DW-1:0] wb_data,
    output logic          wb_valid,
    output logic          mem_err
);

    logic          valid_q;
    logic [1:0]    wb_q;
    logic [2:0]    m_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] result_q;
    logic [DW-1:0] pcbr_q;
    logic [2:0]    bcond_q;
    logic [2:0]    flags_q;

    state_t        state_q;
    state_t        state_d;

    logic [1:0]    wbo_q;
    logic [DW-1:0] wbd_q;
    logic          wbv_q;

    logic          cond_true;
    logic          is_mem;
    logic          is_ld;
    logic          req;
    logic          abort;
    logic          tmo_hit;

    branch_unit u_branch (
        .bcond_i     (bcond_q),
        .flags_i     (flags_q),
        .cond_true_o (cond_true)
    );

    // Branches never touch memory; RD+WR together behaves as a write
    assign is_mem = valid_q & ~m_q[M_BR] & (m_q[M_RD] | m_q[M_WR]);
    assign is_ld  = m_q[M_RD] & ~m_q[M_WR] & ~m_q[M_BR];

    assign taken    = valid_q & m_q[M_BR] & cond_true;
    assign PCtarget = pcbr_q;
    assign flags    = flags_q;

    assign mem.mem_req   = req;
    assign mem.mem_we    = req & m_q[M_WR];
    assign mem.mem_addr  = req ? addr_q : '0;
    assign mem.mem_wdata = req ? data_q : '0;

    assign WB       = wbo_q;
    assign wb_data  = wbd_q;
    assign wb_valid = wbv_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign mem_err = err_q;

    // Count BUSY cycles without ack; remember any abort until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == BUSY && !mem.mem_ack)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
            err_q <= err_q | abort;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign mem_err = 1'b0;

    if (TIMEOUT_CYC < 1) begin : g_tmo_range
    end
`endif

    // Memory handshake next-state and stall generation
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_mem) begin
                    req = 1'b1;
                    if (!mem.mem_ack) begin
                        state_d = BUSY;
                        stall   = 1'b1;
                    end
                end
            end
            BUSY: begin
                req = 1'b1;
                if (mem.mem_ack) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Stage register: load EX bundle unless stalled; squash on taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            wb_q     <= '0;
            m_q      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            pcbr_q   <= '0;
            bcond_q  <= '0;
        end else if (!stall) begin
            valid_q  <= ex_valid & ~taken;
            wb_q     <= WB_in;
            m_q      <= M_in;
            addr_q   <= addr;
            data_q   <= data;
            result_q <= result;
            pcbr_q   <= PCbranch;
            bcond_q  <= bcond;
        end
    end

    // Architectural flags: per-bit update from a real, unsquashed capture
    always_ff @(posedge clk) begin
        if (!rst)
            flags_q <= '0;
        else if (!stall && ex_valid && !taken)
            flags_q <= (flags_q & ~flags_we) | (flags_in & flags_we);
    end

    // MEM/WB register: instruction leaving MEM; bubble while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            wbv_q <= 1'b0;
            wbo_q <= '0;
            wbd_q <= '0;
        end else if (stall) begin
            wbv_q <= 1'b0;
        end else begin
            wbv_q <= valid_q & ~abort;
            wbo_q <= wb_q;
            wbd_q <= is_ld ? mem.mem_rdata : result_q;
        end
    end

endmodule

// File: tb/tb_mem_slice.sv
// tb_mem_slice: directed self-checking bench for mem_slice.
// Build with +define+MEM_TIMEOUT_EN to exercise the timeout path.
module tb_mem_slice;

    logic        clk;
    logic        rst;
    logic [1:0]  WB_in;
    logic [2:0]  M_in;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] result;
    logic [2:0]  flags_in;
    logic [2:0]  flags_we;
    logic [15:0] PCbranch;
    logic [2:0]  bcond;
    logic        ex_valid;
    logic        stall;
    logic        taken;
    logic [15:0] PCtarget;
    logic [2:0]  flags;
    logic [1:0]  WB;
    logic [15:0] wb_data;
    logic        wb_valid;
    logic        mem_err;

    int n_vec;
    int n_err;

    mem_slice_if #(.DW(16)) mif ();

    mem_slice #(
        .DW          (16),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .WB_in    (WB_in),
        .M_in     (M_in),
        .addr     (addr),
        .data     (data),
        .result   (result),
        .flags_in (flags_in),
        .flags_we (flags_we),
        .PCbranch (PCbranch),
        .bcond    (bcond),
        .ex_valid (ex_valid),
        .mem      (mif),
        .stall    (stall),
        .taken    (taken),
        .PCtarget (PCtarget),
        .flags    (flags),
        .WB       (WB),
        .wb_data  (wb_data),
        .wb_valid (wb_valid),
        .mem_err  (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [1:0] wb,
                            input logic [2:0] m, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] r,
                            input logic [2:0] fi, input logic [2:0] fwe,
                            input logic [15:0] pc, input logic [2:0] bc);
        ex_valid = v;
        WB_in    = wb;
        M_in     = m;
        addr     = a;
        data     = d;
        result   = r;
        flags_in = fi;
        flags_we = fwe;
        PCbranch = pc;
        bcond    = bc;
    endtask

    task automatic bubble();
        drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic randomize_inputs();
        drive_ex(1'($urandom), 2'($urandom), 3'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
                 16'($urandom), 3'($urandom));
        mif.mem_ack   = 1'($urandom);
        mif.mem_rdata = 16'($urandom);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        randomize_inputs();

        // reset with random inputs
        tick();
        randomize_inputs();
        tick();
        randomize_inputs();
        #1;
        check("rst_req",    16'(mif.mem_req),   16'h0);
        check("rst_we",     16'(mif.mem_we),    16'h0);
        check("rst_addr",   mif.mem_addr,       16'h0);
        check("rst_wdata",  mif.mem_wdata,      16'h0);
        check("rst_stall",  16'(stall),         16'h0);
        check("rst_taken",  16'(taken),         16'h0);
        check("rst_pct",    PCtarget,           16'h0);
        check("rst_flags",  16'(flags),         16'h0);
        check("rst_wb",     16'(WB),            16'h0);
        check("rst_wbdata", wb_data,            16'h0);
        check("rst_wbv",    16'(wb_valid),      16'h0);
        check("rst_err",    16'(mem_err),       16'h0);

        rst           = 1'b1;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'h0;
        bubble();
        tick();

        // ADD sets flags 100, BEQ taken, wrong-path squashed
        drive_ex(1, 2'b01, 3'b000, 0, 0, 16'h0005, 3'b100, 3'b111, 0, 3'b000);
        tick();
        drive_ex(1, 2'b00, 3'b100, 0, 0, 0, 0, 0, 16'h0040, 3'b001);
        tick();
        check("add_wbv",   16'(wb_valid), 16'h1);
        check("add_wbd",   wb_data,       16'h0005);
        check("add_wb",    16'(WB),       16'h1);
        check("add_flags", 16'(flags),    16'h4);
        check("beq_taken", 16'(taken),    16'h1);
        check("beq_pct",   PCtarget,      16'h0040);
        check("beq_noreq", 16'(mif.mem_req), 16'h0);
        drive_ex(1, 2'b11, 3'b000, 0, 0, 16'h0099, 3'b001, 3'b111, 0, 0);
        tick();
        check("sq_flags",  16'(flags),    16'h4);
        check("sq_taken",  16'(taken),    16'h0);
        check("beq_wbv",   16'(wb_valid), 16'h1);
        bubble();
        tick();
        check("sq_wbv",    16'(wb_valid), 16'h0);

        // load with ack on the third request cycle
        drive_ex(1, 2'b10, 3'b001, 16'h0010, 0, 16'h1111, 0, 0, 0, 0);
        tick();
        drive_ex(1, 2'b01, 3'b000, 0, 0, 16'h0077, 0, 0, 0, 0);
        check("ld1_req",   16'(mif.mem_req), 16'h1);
        check("ld1_addr",  mif.mem_addr,     16'h0010);
        check("ld1_we",    16'(mif.mem_we),  16'h0);
        check("ld1_stall", 16'(stall),       16'h1);
        tick();
        check("ld2_req",   16'(mif.mem_req), 16'h1);
        check("ld2_addr",  mif.mem_addr,     16'h0010);
        check("ld2_stall", 16'(stall),       16'h1);
        check("ld2_wbv",   16'(wb_valid),    16'h0);
        tick();
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 16'hBEEF;
        #1;
        check("ld3_req",   16'(mif.mem_req), 16'h1);
        check("ld3_addr",  mif.mem_addr,     16'h0010);
        check("ld3_stall", 16'(stall),       16'h0);
        tick();
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'h0;
        bubble();
        #1;
        check("ld_wbd",    wb_data,          16'hBEEF);
        check("ld_wbv",    16'(wb_valid),    16'h1);
        check("ld_wb",     16'(WB),          16'h2);
        check("ld_noreq",  16'(mif.mem_req), 16'h0);
        tick();
        check("nxt_wbd",   wb_data,          16'h0077);
        check("nxt_wbv",   16'(wb_valid),    16'h1);

        // store acked in the request cycle
        drive_ex(1, 2'b00, 3'b010, 16'h0020, 16'h1234, 0, 0, 0, 0, 0);
        tick();
        bubble();
        mif.mem_ack = 1'b1;
        #1;
        check("st_req",    16'(mif.mem_req), 16'h1);
        check("st_we",     16'(mif.mem_we),  16'h1);
        check("st_addr",   mif.mem_addr,     16'h0020);
        check("st_wdata",  mif.mem_wdata,    16'h1234);
        check("st_stall",  16'(stall),       16'h0);
        tick();
        mif.mem_ack = 1'b0;
        #1;
        check("st_stall2", 16'(stall),       16'h0);
        check("st_wbv",    16'(wb_valid),    16'h1);

        // RD+WR together behaves as a write, result written back
        drive_ex(1, 2'b01, 3'b011, 16'h0028, 16'h5555, 16'h0AAA, 0, 0, 0, 0);
        tick();
        bubble();
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 16'hDEAD;
        #1;
        check("rw_we",     16'(mif.mem_we),  16'h1);
        tick();
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'h0;
        check("rw_wbd",    wb_data,          16'h0AAA);

        // clear flags, BNE taken squashes flag-setting SUB, BLT not taken
        drive_ex(1, 2'b01, 3'b000, 0, 0, 16'h0001, 3'b000, 3'b111, 0, 0);
        tick();
        drive_ex(1, 2'b00, 3'b100, 0, 0, 0, 0, 0, 16'h0080, 3'b000);
        tick();
        check("clr_flags", 16'(flags),    16'h0);
        check("bne_taken", 16'(taken),    16'h1);
        check("bne_pct",   PCtarget,      16'h0080);
        drive_ex(1, 2'b01, 3'b000, 0, 0, 16'h00FF, 3'b010, 3'b111, 0, 0);
        tick();
        check("sub_flags", 16'(flags),    16'h0);
        drive_ex(1, 2'b00, 3'b100, 0, 0, 0, 0, 0, 16'h0090, 3'b011);
        tick();
        check("blt_taken", 16'(taken),    16'h0);
        check("sub_wbv",   16'(wb_valid), 16'h0);
        bubble();
        tick();

`ifdef MEM_TIMEOUT_EN
        // load never acked: abort after 4 BUSY cycles
        drive_ex(1, 2'b10, 3'b001, 16'h0030, 0, 0, 0, 0, 0, 0);
        tick();
        bubble();
        check("to_idle_stall", 16'(stall), 16'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_busy_stall", 16'(stall),       16'h1);
            check("to_busy_req",   16'(mif.mem_req), 16'h1);
        end
        tick();
        check("to_last_stall", 16'(stall), 16'h0);
        tick();
        check("to_req",   16'(mif.mem_req), 16'h0);
        check("to_err",   16'(mem_err),     16'h1);
        check("to_stall", 16'(stall),       16'h0);
        check("to_wbv",   16'(wb_valid),    16'h0);
        tick();
        tick();
        tick();
        check("to_sticky", 16'(mem_err), 16'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("to_err_clr", 16'(mem_err), 16'h0);
        tick();
`else
        // load never acked: BUSY waits indefinitely
        drive_ex(1, 2'b10, 3'b001, 16'h0030, 0, 0, 0, 0, 0, 0);
        tick();
        bubble();
        for (int i = 0; i < 8; i++) tick();
        check("wait_stall", 16'(stall),       16'h1);
        check("wait_req",   16'(mif.mem_req), 16'h1);
        check("wait_err",   16'(mem_err),     16'h0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`endif

        // reset while an access is outstanding; late ack ignored
        drive_ex(1, 2'b10, 3'b001, 16'h0044, 0, 0, 0, 0, 0, 0);
        tick();
        bubble();
        tick();
        check("mr_stall", 16'(stall), 16'h1);
        rst = 1'b0;
        tick();
        rst           = 1'b1;
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 16'hCAFE;
        #1;
        check("mr_req",   16'(mif.mem_req), 16'h0);
        check("mr_stall2", 16'(stall),      16'h0);
        tick();
        mif.mem_ack = 1'b0;
        check("mr_wbv",   16'(wb_valid),    16'h0);
        check("mr_wbd",   wb_data,          16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
